// File: rtl/pila_param_pkg.sv
// Shared CPU constants for the return-address stack: default PC width,
// default stack depth, overflow-mode encodings and request decoding.
package pila_param_pkg;

  // Default return-address width and number of stack entries
  localparam int PC_WIDTH    = 10;
  localparam int STACK_DEPTH = 8;

  // Behaviour of a push while the stack is full
  localparam int WRAP_DROP      = 0;
  localparam int WRAP_OVERWRITE = 1;

  // Request seen in one cycle, encoded as {pop, push}
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_PUSH = 2'b01,
    REQ_POP  = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;

  // Fold the two request strobes into a single request code
  function automatic req_e decode_req(input logic push, input logic pop);
    logic [1:0] raw_s;
    raw_s = {pop, push};
    return req_e'(raw_s);
  endfunction

endpackage

// File: rtl/pila_ctrl.sv
// Return-address stack control: write pointer, entry count, sticky error
// flags and request decoding. Produces the write strobe/address for the
// storage array and the index of the current top entry.
import pila_param_pkg::*;

module pila_ctrl #(
  parameter int DEPTH = STACK_DEPTH,
  parameter int WRAP  = WRAP_DROP,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  // Width-exact constants so pointer and count arithmetic never truncates
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);
  localparam logic [AW-1:0] ONE_P    = AW'(1);
  localparam logic [AW-1:0] ZERO_P   = AW'(0);

  logic [AW-1:0] wp_r;
  logic [AW-1:0] wp_nxt_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          ovf_r;
  logic          udf_r;
  logic          ovf_nxt_s;
  logic          udf_nxt_s;
  logic          ovf_evt_s;
  logic          udf_evt_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [AW-1:0] top_s;
  logic          empty_s;
  logic          full_s;
  req_e          req_s;

  assign empty_s = (count_r == ZERO_C);
  assign full_s  = (count_r == DEPTH_C);
  // Top entry sits just below the write pointer, modulo DEPTH
  assign top_s   = wp_r - ONE_P;

  // Decode the request against the current fill level into next state
  always_comb begin
    req_s       = decode_req(push, pop);
    wp_nxt_s    = wp_r;
    count_nxt_s = count_r;
    ovf_evt_s   = 1'b0;
    udf_evt_s   = 1'b0;
    we_s        = 1'b0;
    waddr_s     = wp_r;
    case (req_s)
      REQ_PUSH: begin
        if (!full_s) begin
          we_s        = 1'b1;
          wp_nxt_s    = wp_r + ONE_P;
          count_nxt_s = count_r + ONE_C;
        end else if (WRAP == WRAP_OVERWRITE) begin
          // Oldest entry is overwritten; count stays at DEPTH
          we_s      = 1'b1;
          wp_nxt_s  = wp_r + ONE_P;
          ovf_evt_s = 1'b1;
        end else begin
          ovf_evt_s = 1'b1;
        end
      end
      REQ_POP: begin
        if (!empty_s) begin
          wp_nxt_s    = wp_r - ONE_P;
          count_nxt_s = count_r - ONE_C;
        end else begin
          udf_evt_s = 1'b1;
        end
      end
      REQ_BOTH: begin
        if (!empty_s) begin
          // Return-then-call: replace the top entry in place, never an error
          we_s    = 1'b1;
          waddr_s = top_s;
        end else begin
          // Nothing to return from: act as a plain push, flag the bad pop
          we_s        = 1'b1;
          wp_nxt_s    = wp_r + ONE_P;
          count_nxt_s = count_r + ONE_C;
          udf_evt_s   = 1'b1;
        end
      end
      REQ_NONE: begin
        we_s = 1'b0;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
    // Sticky flags: a new error event wins over a same-cycle clear
    ovf_nxt_s = (ovf_r & ~clr_err) | ovf_evt_s;
    udf_nxt_s = (udf_r & ~clr_err) | udf_evt_s;
  end

  // Pointer, count and flag registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_r    <= ZERO_P;
      count_r <= ZERO_C;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      wp_r    <= wp_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      udf_r   <= udf_nxt_s;
    end
  end

  // Array writes are suppressed while reset is held so reset wins over a push
  assign we        = we_s & ~reset;
  assign waddr     = waddr_s;
  assign top       = top_s;
  assign count     = count_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = ovf_r;
  assign underflow = udf_r;

endmodule

// File: rtl/pila_param.sv
// Parameterised return-address stack: circular storage array plus the
// pila_ctrl pointer/count/flag block. DEPTH must be a power of two >= 2
// so the write pointer wraps naturally modulo DEPTH.
import pila_param_pkg::*;

module pila_param #(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int WRAP  = WRAP_DROP,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [AW-1:0]    top_s;
  logic             empty_s;

  pila_ctrl #(
    .DEPTH (DEPTH),
    .WRAP  (WRAP)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .we        (we_s),
    .waddr     (waddr_s),
    .top       (top_s),
    .count     (count),
    .empty     (empty_s),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= din;
    end
  end

  // Top-of-stack read, masked to zero when empty so stale data never leaks
  always_comb begin
    if (empty_s) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_r[top_s];
    end
  end

  assign empty = empty_s;

endmodule
